alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 189 ++++++++++++++++++
 tb/tb_alu_muldiv.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - single-cycle ALU with iterative multiply/divide and HI/LO registers
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (accept = in_valid && in_ready)
//   op, op1, op2         operation code and operands
//   shamt, var_shift     immediate shift amount / select op1[SH_W-1:0] as amount
//   out_valid, result    one-cycle result pulse; result holds between pulses
//   hi, lo               HI/LO registers written by MULT/MULTU/DIV/DIVU only
//   busy                 multi-cycle operation in progress (!in_ready)
//   div_zero             last completed DIV/DIVU divided by zero (sticky)
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SH_W-1:0]  shamt,
    input  logic             var_shift,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             div_zero
);
    localparam logic [3:0] OP_MULT  = 4'b0000, OP_MULTU = 4'b1001, OP_DIV  = 4'b1101,
                           OP_DIVU  = 4'b1100, OP_ADDU  = 4'b0001, OP_SUBU = 4'b0011,
                           OP_AND   = 4'b0100, OP_OR    = 4'b0101, OP_XOR  = 4'b0110,
                           OP_NOR   = 4'b0111, OP_SLT   = 4'b0010, OP_SLTU = 4'b1000,
                           OP_SLL   = 4'b1110, OP_SRL   = 4'b1010, OP_SRA  = 4'b1011,
                           OP_LUI   = 4'b1111;
    localparam logic [SH_W-1:0] LAST = SH_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    state_t state, state_next;

    logic [SH_W-1:0]  cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, mcand, op1_q;
    logic             neg_lo, neg_hi, dz_pend, is_div;

    logic             accept, is_mul_op, is_div_op, sgn, op1_neg, op2_neg;
    logic [WIDTH-1:0] op1_mag, op2_mag, alu;
    logic [SH_W-1:0]  sa;

    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign accept    = in_valid && in_ready;
    assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);
    assign sgn       = (op == OP_MULT) || (op == OP_DIV);
    assign op1_neg   = sgn && op1[WIDTH-1];
    assign op2_neg   = sgn && op2[WIDTH-1];
    // The most-negative value's magnitude still fits as an unsigned WIDTH-bit number.
    assign op1_mag   = op1_neg ? -op1 : op1;
    assign op2_mag   = op2_neg ? -op2 : op2;
    assign sa        = var_shift ? op1[SH_W-1:0] : shamt;

    always_comb begin
        alu = '0;
        case (op)
            OP_ADDU: alu = op1 + op2;
            OP_SUBU: alu = op1 - op2;
            OP_AND:  alu = op1 & op2;
            OP_OR:   alu = op1 | op2;
            OP_XOR:  alu = op1 ^ op2;
            OP_NOR:  alu = ~(op1 | op2);
            OP_SLT:  alu = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            OP_SLTU: alu = {{(WIDTH-1){1'b0}}, op1 < op2};
            OP_SLL:  alu = op2 << sa;
            OP_SRL:  alu = op2 >> sa;
            OP_SRA:  alu = WIDTH'($signed(op2) >>> sa);
            OP_LUI:  alu = op2 << (WIDTH / 2);
            default: alu = '0;
        endcase
    end

    // Shift-add step: {acc_hi, acc_lo} shifts right, multiplier bits leave from acc_lo[0].
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);

    // Restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, mcand};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mcand}) : div_shift[WIDTH-1:0];

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    assign prod = {acc_hi, acc_lo};

    always_comb begin
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div) begin
            if (neg_lo) {fix_hi, fix_lo} = -prod;
        end else if (dz_pend) begin
            fix_hi = op1_q;
            fix_lo = '1;
        end else begin
            if (neg_lo) fix_lo = -acc_lo;
            if (neg_hi) fix_hi = -acc_hi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul_op)      state_next = MUL;
                else if (accept && is_div_op) state_next = DIV;
            end
            MUL, DIV: if (cnt == LAST) state_next = FIX;
            FIX:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            mcand     <= '0;
            op1_q     <= '0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            dz_pend   <= 1'b0;
            is_div    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (is_mul_op || is_div_op) begin
                        acc_hi  <= '0;
                        acc_lo  <= op1_mag;
                        mcand   <= op2_mag;
                        op1_q   <= op1;
                        is_div  <= is_div_op;
                        neg_lo  <= op1_neg ^ op2_neg;
                        neg_hi  <= op1_neg;
                        dz_pend <= is_div_op && (op2 == '0);
                        cnt     <= '0;
                        if (is_div_op) div_zero <= 1'b0;
                    end else begin
                        result    <= alu;
                        out_valid <= 1'b1;
                    end
                end
                MUL: begin
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                end
                DIV: begin
                    acc_hi <= div_rem;
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                end
                FIX: begin
                    hi        <= fix_hi;
                    lo        <= fix_lo;
                    result    <= fix_lo;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    if (is_div && dz_pend) div_zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - self-checking bench for alu_muldiv (WIDTH = 32)
module tb_alu_muldiv;
    localparam logic [3:0] OP_MULT  = 4'b0000, OP_MULTU = 4'b1001, OP_DIV  = 4'b1101,
                           OP_DIVU  = 4'b1100, OP_ADDU  = 4'b0001, OP_SUBU = 4'b0011,
                           OP_AND   = 4'b0100, OP_OR    = 4'b0101, OP_XOR  = 4'b0110,
                           OP_NOR   = 4'b0111, OP_SLT   = 4'b0010, OP_SLTU = 4'b1000,
                           OP_SLL   = 4'b1110, OP_SRL   = 4'b1010, OP_SRA  = 4'b1011,
                           OP_LUI   = 4'b1111;

    logic        clk, rst_n, in_valid, in_ready, var_shift, out_valid, busy, div_zero;
    logic [3:0]  op;
    logic [31:0] op1, op2, result, hi, lo;
    logic [4:0]  shamt;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op1(op1), .op2(op2), .shamt(shamt), .var_shift(var_shift),
        .out_valid(out_valid), .result(result), .hi(hi), .lo(lo),
        .busy(busy), .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference state: architectural HI/LO/div_zero as the spec defines them.
    logic [31:0] m_hi = 0, m_lo = 0;
    logic        m_dz = 0;

    function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic vs,
                                  output logic [31:0] res, output logic md);
        int          sa;
        longint      sp;
        logic [63:0] up;
        int          x, y;
        logic signed [31:0] sb;
        sa  = vs ? int'(a[4:0]) : int'(sh);
        md  = 1'b0;
        res = 0;
        sb  = b;
        case (o)
            OP_MULT:  begin sp = longint'($signed(a)) * longint'($signed(b)); {m_hi, m_lo} = sp; md = 1; end
            OP_MULTU: begin up = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = up; md = 1; end
            OP_DIV: begin
                md = 1;
                if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; m_dz = 1; end
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_lo = a; m_hi = 0; m_dz = 0; end
                else begin x = a; y = b; m_lo = x / y; m_hi = x % y; m_dz = 0; end
            end
            OP_DIVU: begin
                md = 1;
                if (b == 0) begin m_lo = 32'hFFFFFFFF; m_hi = a; m_dz = 1; end
                else begin m_lo = a / b; m_hi = a % b; m_dz = 0; end
            end
            OP_ADDU: res = a + b;
            OP_SUBU: res = a - b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOR:  res = ~(a | b);
            OP_SLT:  res = ($signed(a) < $signed(b)) ? 1 : 0;
            OP_SLTU: res = (a < b) ? 1 : 0;
            OP_SLL:  res = b << sa;
            OP_SRL:  res = b >> sa;
            OP_SRA:  res = sb >>> sa;
            OP_LUI:  res = b << 16;
            default: res = 0;
        endcase
        if (md) res = m_lo;
    endfunction

    // Called at a falling edge; returns at the falling edge where out_valid is seen.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input logic vs,
                          output logic [31:0] r_res, output logic [31:0] r_hi,
                          output logic [31:0] r_lo, output logic r_dz,
                          output int lat, output int bsy);
        int w;
        in_valid = 1; op = o; op1 = a; op2 = b; shamt = sh; var_shift = vs;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        if (!in_ready) chk("accept_wait", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 0;
        lat = 1; bsy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) bsy++;
            @(negedge clk);
            lat++;
        end
        r_res = result; r_hi = hi; r_lo = lo; r_dz = div_zero;
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic        vs;
        logic [31:0] res, hi, lo;
        logic        dz;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] g_res, g_hi, g_lo, e_res;
        logic        g_dz, md;
        int          lat, bsy, pulses;
        logic [3:0]  ro;
        logic [31:0] ra, rb;
        logic [4:0]  rsh;
        logic        rvs;

        vecs[0]  = '{OP_ADDU,  32'hFFFFFFFF, 32'h2,        5'd0, 1'b0, 32'h1,        32'h0,        32'h0,        1'b0};
        vecs[1]  = '{OP_SRA,   32'h0,        32'h80000000, 5'd4, 1'b0, 32'hF8000000, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{OP_MULT,  32'hFFFFFFFD, 32'h7,        5'd0, 1'b0, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[3]  = '{OP_SUBU,  32'h0,        32'h1,        5'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[4]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h1,        32'hFFFFFFFE, 32'h1,        1'b0};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        5'd0, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[6]  = '{OP_DIVU,  32'd100,      32'd7,        5'd0, 1'b0, 32'd14,       32'd2,        32'd14,       1'b0};
        vecs[7]  = '{OP_DIV,   32'd5,        32'd0,        5'd0, 1'b0, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[8]  = '{OP_SLT,   32'hFFFFFFFF, 32'h1,        5'd0, 1'b0, 32'h1,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[9]  = '{OP_SLTU,  32'hFFFFFFFF, 32'h1,        5'd0, 1'b0, 32'h0,        32'd5,        32'hFFFFFFFF, 1'b1};
        vecs[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0, 32'h80000000, 32'h0,        32'h80000000, 1'b0};
        vecs[11] = '{OP_SLL,   32'h23,       32'h1,        5'd7, 1'b1, 32'h8,        32'h0,        32'h80000000, 1'b0};
        vecs[12] = '{OP_LUI,   32'h0,        32'h1234,     5'd0, 1'b0, 32'h12340000, 32'h0,        32'h80000000, 1'b0};
        vecs[13] = '{OP_NOR,   32'h0,        32'h0,        5'd0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0};
        vecs[14] = '{OP_SRL,   32'h0,        32'h80000000, 5'd31,1'b0, 32'h1,        32'h0,        32'h80000000, 1'b0};

        rst_n = 0; in_valid = 0; op = 0; op1 = 0; op2 = 0; shamt = 0; var_shift = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_div_zero", {63'b0, div_zero}, 64'd0);
        rst_n = 1;

        // Directed table; first accept lands on the first rising edge after release.
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].vs, g_res, g_hi, g_lo, g_dz, lat, bsy);
            model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].vs, e_res, md);
            chk($sformatf("vec%0d_result", i), {32'b0, g_res}, {32'b0, vecs[i].res});
            chk($sformatf("vec%0d_hi", i), {32'b0, g_hi}, {32'b0, vecs[i].hi});
            chk($sformatf("vec%0d_lo", i), {32'b0, g_lo}, {32'b0, vecs[i].lo});
            chk($sformatf("vec%0d_div_zero", i), {63'b0, g_dz}, {63'b0, vecs[i].dz});
            chk($sformatf("vec%0d_latency", i), 64'(lat), md ? 64'd34 : 64'd1);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bsy), md ? 64'd33 : 64'd0);
        end

        // Back-to-back single-cycle accepts.
        in_valid = 1; op = OP_ADDU; op1 = 32'hFFFFFFFF; op2 = 32'h2; var_shift = 0; shamt = 0;
        @(negedge clk);
        chk("b2b_valid0", {63'b0, out_valid}, 64'd1);
        chk("b2b_result0", {32'b0, result}, 64'h1);
        op = OP_SRA; op1 = 0; op2 = 32'h80000000; shamt = 5'd4;
        @(negedge clk);
        in_valid = 0;
        chk("b2b_valid1", {63'b0, out_valid}, 64'd1);
        chk("b2b_result1", {32'b0, result}, 64'hF8000000);
        chk("b2b_hilo", {hi, lo}, {m_hi, m_lo});
        @(negedge clk);
        chk("b2b_idle_valid", {63'b0, out_valid}, 64'd0);
        chk("b2b_result_hold", {32'b0, result}, 64'hF8000000);

        // Request held valid while busy is only taken once in_ready returns.
        in_valid = 1; op = OP_MULTU; op1 = 3; op2 = 5;
        @(negedge clk);
        op = OP_ADDU; op1 = 10; op2 = 20;
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        model(OP_MULTU, 3, 5, 0, 0, e_res, md);
        chk("held_mul_latency", 64'(lat), 64'd34);
        chk("held_mul_result", {32'b0, result}, 64'd15);
        chk("held_mul_hilo", {hi, lo}, {m_hi, m_lo});
        chk("held_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        in_valid = 0;
        chk("held_add_valid", {63'b0, out_valid}, 64'd1);
        chk("held_add_result", {32'b0, result}, 64'd30);
        @(negedge clk);
        chk("held_add_single", {63'b0, out_valid}, 64'd0);

        // Reset in the middle of a MULTU.
        in_valid = 1; op = OP_MULTU; op1 = 32'h12345; op2 = 32'h6789;
        @(negedge clk);
        in_valid = 0;
        repeat (9) @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        m_hi = 0; m_lo = 0; m_dz = 0;
        run_op(OP_SLTU, 1, 2, 0, 0, g_res, g_hi, g_lo, g_dz, lat, bsy);
        chk("abort_sltu_latency", 64'(lat), 64'd1);
        chk("abort_sltu_result", {32'b0, g_res}, 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        chk("abort_no_pulse", 64'(pulses), 64'd0);
        chk("abort_hilo_after", {hi, lo}, 64'd0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 80; i++) begin
            ro = 4'($urandom_range(0, 15)); ra = pick(); rb = pick();
            rsh = 5'($urandom); rvs = 1'($urandom_range(0, 1));
            run_op(ro, ra, rb, rsh, rvs, g_res, g_hi, g_lo, g_dz, lat, bsy);
            model(ro, ra, rb, rsh, rvs, e_res, md);
            chk($sformatf("rnd%0d_op%0h_result", i, ro), {32'b0, g_res}, {32'b0, e_res});
            chk($sformatf("rnd%0d_op%0h_hilo", i, ro), {g_hi, g_lo}, {m_hi, m_lo});
            chk($sformatf("rnd%0d_op%0h_div_zero", i, ro), {63'b0, g_dz}, {63'b0, m_dz});
            chk($sformatf("rnd%0d_op%0h_latency", i, ro), 64'(lat), md ? 64'd34 : 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
